// File: rtl/config_flit_arbiter.sv
// -----------------------------------------------------------------------------
// config_flit_arbiter
//
// Shares the single configuration-flit path into the configurator among
// NUM_REQ sources (host queue, management/JTAG, self-test, ...).
// Arbitration is round-robin. When MAX_BURST > 1 the winner keeps the grant
// for up to MAX_BURST consecutive flits, so a multi-flit configuration stays
// contiguous. The output is a single registered stage that feeds the
// configurator's in_config_* valid/ready handshake.
//
// Parameters
//   NUM_REQ    number of requesters (>= 2)
//   DATA_W     configuration flit width
//   MAX_BURST  flits one owner may send back-to-back; 1 = plain per-flit RR
//   SRC_W      width of the requester index (derived)
//
// Ports
//   clk           clock
//   rst           asynchronous, active-high reset
//   in_data       flit of requester i at [i*DATA_W +: DATA_W]
//   in_valid      requester i offers a flit
//   in_ready      requester i's flit is taken this cycle (one-hot or zero)
//   out_data      registered flit towards the configurator
//   out_valid     out_data is valid
//   out_ready     configurator accepts out_data
//   out_src       requester index that produced out_data
//   out_flit_cnt  flits delivered (out_valid & out_ready), wraps at 2^32
// -----------------------------------------------------------------------------
module config_flit_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_W    = 512,
  parameter  int MAX_BURST = 4,
  localparam int SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_valid,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [SRC_W-1:0]          out_src,
  output logic [31:0]               out_flit_cnt
);

  localparam int BC_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0] owner_q, owner_d;
  logic [BC_W-1:0]  burst_cnt_q, burst_cnt_d;

  logic              take_p0;
  logic              keep_owner_p0;
  logic [SRC_W-1:0]  scan_base_p0;
  logic [SRC_W-1:0]  cand_p0;
  logic              gnt_vld_p0;
  logic [SRC_W-1:0]  gnt_idx_p0;
  logic [DATA_W-1:0] gnt_data_p0;

  // Index addition modulo NUM_REQ. Both operands are below NUM_REQ, so a
  // single conditional subtract is enough, also for non-power-of-2 NUM_REQ.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                input int               ofs);
    int sum;
    sum = int'(32'(base)) + ofs;
    if (sum >= NUM_REQ) begin
      sum = sum - NUM_REQ;
    end
    return SRC_W'(sum);
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: grant selection (combinational)
  // ---------------------------------------------------------------------------
  assign take_p0 = !out_valid || out_ready;

  always_comb begin
    keep_owner_p0 = (state_q == OWN) && in_valid[owner_q];
    // When the owner runs dry the scan restarts right after it, in the same
    // cycle, so the hand-over costs no bubble.
    scan_base_p0  = (state_q == OWN) ? wrap_add(owner_q, 1) : rr_ptr_q;
    cand_p0       = '0;
    gnt_vld_p0    = 1'b0;
    gnt_idx_p0    = '0;
    if (keep_owner_p0) begin
      gnt_vld_p0 = 1'b1;
      gnt_idx_p0 = owner_q;
    end else begin
      // Walk from the far end towards the base so the closest valid
      // requester is the last one written and therefore wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        cand_p0 = wrap_add(scan_base_p0, k);
        if (in_valid[cand_p0]) begin
          gnt_vld_p0 = 1'b1;
          gnt_idx_p0 = cand_p0;
        end
      end
    end
  end

  always_comb begin
    gnt_data_p0 = in_data[int'(32'(gnt_idx_p0)) * DATA_W +: DATA_W];
  end

  always_comb begin
    in_ready = '0;
    if (!rst && take_p0 && gnt_vld_p0) begin
      in_ready[gnt_idx_p0] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration state (advances only when the output stage can take a flit)
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    if (take_p0) begin
      if (keep_owner_p0) begin
        if (int'(32'(burst_cnt_q)) + 1 == MAX_BURST) begin
          rr_ptr_d    = wrap_add(owner_q, 1);
          burst_cnt_d = '0;
          state_d     = IDLE;
        end else begin
          burst_cnt_d = burst_cnt_q + BC_W'(1);
        end
      end else begin
        if (state_q == OWN) begin
          rr_ptr_d = wrap_add(owner_q, 1);
        end
        if (gnt_vld_p0) begin
          if (MAX_BURST == 1) begin
            rr_ptr_d = wrap_add(gnt_idx_p0, 1);
            state_d  = IDLE;
          end else begin
            owner_d     = gnt_idx_p0;
            burst_cnt_d = BC_W'(1);
            state_d     = OWN;
          end
        end else begin
          burst_cnt_d = '0;
          state_d     = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered output towards the configurator
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (take_p0) begin
      out_valid <= gnt_vld_p0;
      if (gnt_vld_p0) begin
        out_data <= gnt_data_p0;
        out_src  <= gnt_idx_p0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_flit_cnt <= '0;
    end else if (out_valid && out_ready) begin
      out_flit_cnt <= out_flit_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_config_flit_arbiter.sv
module tb_config_flit_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N*DW-1:0] din = '0;
  logic [N-1:0]    vin = '0;
  logic            ordy = 1'b1;

  logic [N-1:0]  ir4, ir1;
  logic [DW-1:0] od4, od1;
  logic          ov4, ov1;
  logic [1:0]    os4, os1;
  logic [31:0]   cnt4, cnt1;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  config_flit_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut_b4 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vin), .in_ready(ir4),
    .out_data(od4), .out_valid(ov4), .out_ready(ordy), .out_src(os4),
    .out_flit_cnt(cnt4));

  config_flit_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst(rst), .in_data(din), .in_valid(vin), .in_ready(ir1),
    .out_data(od1), .out_valid(ov1), .out_ready(ordy), .out_src(os1),
    .out_flit_cnt(cnt1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: index 0 = burst 4, index 1 = burst 1
  int          lim     [2] = '{4, 1};
  int          m_start [2];
  int          m_owner [2];
  int          m_run   [2];   // flits sent in the current burst, 0 = no burst
  logic        m_ov    [2];
  logic [DW-1:0] m_od  [2];
  int          m_os    [2];
  logic [31:0] m_cnt   [2];

  function automatic int pick(input int d);
    int base;
    if (m_run[d] > 0 && vin[m_owner[d]]) return m_owner[d];
    base = (m_run[d] > 0) ? m_owner[d] + 1 : m_start[d];
    for (int k = 0; k < N; k++)
      if (vin[(base + k) % N]) return (base + k) % N;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_start[d] = 0; m_owner[d] = 0; m_run[d] = 0;
      m_ov[d] = 1'b0; m_od[d] = '0; m_os[d] = 0; m_cnt[d] = '0;
    end
  endtask

  task automatic model_step();
    int p;
    bit take;
    for (int d = 0; d < 2; d++) begin
      take = !m_ov[d] || ordy;
      p = pick(d);
      if (m_ov[d] && ordy) m_cnt[d] = m_cnt[d] + 1;
      if (take) begin
        m_ov[d] = (p >= 0);
        if (p >= 0) begin
          m_od[d] = din[p*DW +: DW];
          m_os[d] = p;
          if (m_run[d] > 0 && p == m_owner[d]) m_run[d]++;
          else begin m_owner[d] = p; m_run[d] = 1; end
          if (m_run[d] == lim[d]) begin
            m_start[d] = (m_owner[d] + 1) % N;
            m_run[d] = 0;
          end
        end else if (m_run[d] > 0) begin
          m_start[d] = (m_owner[d] + 1) % N;
          m_run[d] = 0;
        end
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  function automatic logic [N-1:0] exp_ready(input int d);
    int p;
    if (rst) return '0;
    if (m_ov[d] && !ordy) return '0;
    p = pick(d);
    if (p < 0) return '0;
    return N'(1) << p;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("b4_in_ready", 64'(ir4), 64'(exp_ready(0)));
      chk("b4_out_valid", 64'(ov4), 64'(m_ov[0]));
      chk("b4_cnt", 64'(cnt4), 64'(m_cnt[0]));
      if (m_ov[0]) begin
        chk("b4_out_src", 64'(os4), 64'(m_os[0]));
        chk("b4_out_data", 64'(od4), 64'(m_od[0]));
      end
      chk("b1_in_ready", 64'(ir1), 64'(exp_ready(1)));
      chk("b1_out_valid", 64'(ov1), 64'(m_ov[1]));
      chk("b1_cnt", 64'(cnt1), 64'(m_cnt[1]));
      if (m_ov[1]) begin
        chk("b1_out_src", 64'(os1), 64'(m_os[1]));
        chk("b1_out_data", 64'(od1), 64'(m_od[1]));
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic drive(input logic [N-1:0] v, input logic r);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) din[i*DW +: DW] = DW'($urandom);
    vin  = v;
    ordy = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b1;
    vin = '0;
    ordy = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] v;
    logic         r;
    logic [N-1:0] rdy;
    logic         ov;
    logic [1:0]   src;
  } vec_t;

  vec_t tbl [30];
  logic [31:0] exp_cnt [5] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};

  initial begin
    // burst-4 directed sequence: two-way bursts, early drop, backpressure
    tbl[0]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[2]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[3]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[4]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd0};
    tbl[5]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[6]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[7]  = '{4'b0101, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[8]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd2};
    tbl[9]  = '{4'b0101, 1'b1, 4'b0001, 1'b1, 2'd0};
    tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[12] = '{4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0};
    tbl[13] = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1};
    tbl[14] = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1};
    tbl[15] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[16] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[17] = '{4'b1011, 1'b1, 4'b1000, 1'b1, 2'd3};
    tbl[18] = '{4'b1011, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[19] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
    tbl[20] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    tbl[21] = '{4'b0100, 1'b1, 4'b0100, 1'b0, 2'd0};
    for (int i = 22; i < 27; i++) tbl[i] = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd2};
    tbl[27] = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
    tbl[28] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
    tbl[29] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

    model_reset();
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(ov4), 64'(0));
    chk("rst_out_data", 64'(od4), 64'(0));
    chk("rst_out_src", 64'(os4), 64'(0));
    chk("rst_cnt", 64'(cnt4), 64'(0));
    chk_on = 1'b1;

    // per-flit round robin with all requesters active
    for (int k = 0; k < 8; k++) begin
      drive(4'b1111, 1'b1);
      @(negedge clk);
      chk("rr1_in_ready", 64'(ir1), 64'(4'b0001 << (k % 4)));
      chk("rr1_out_valid", 64'(ov1), 64'(k > 0));
      if (k > 0) chk("rr1_out_src", 64'(os1), 64'((k - 1) % 4));
    end

    do_reset();
    for (int i = 0; i < 30; i++) begin
      drive(tbl[i].v, tbl[i].r);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 64'(ir4), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_out_valid", i), 64'(ov4), 64'(tbl[i].ov));
      if (tbl[i].ov) chk($sformatf("tbl%0d_out_src", i), 64'(os4), 64'(tbl[i].src));
    end

    // randomized traffic with random backpressure
    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] nv;
      nv = ($urandom_range(0, 1) == 0) ? vin : N'($urandom_range(0, 15));
      drive(nv, $urandom_range(0, 3) != 0);
    end

    // asynchronous reset in the middle of a burst
    drive(4'b1111, 1'b1);
    drive(4'b1111, 1'b1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid_b4", 64'(ov4), 64'(0));
    chk("async_rst_valid_b1", 64'(ov1), 64'(0));
    chk("async_rst_ready_b4", 64'(ir4), 64'(0));
    chk("async_rst_ready_b1", 64'(ir1), 64'(0));
    chk("async_rst_cnt", 64'(cnt4), 64'(0));
    @(posedge clk);
    #3 rst = 1'b0;
    vin = 4'b1010;
    @(negedge clk);
    chk("post_rst_grant_b4", 64'(ir4), 64'(4'b0010));
    chk("post_rst_grant_b1", 64'(ir1), 64'(4'b0010));

    // counter wrap-around
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    drive(4'b0000, 1'b1);
    @(negedge clk);
    #1;
    force dut_b4.out_flit_cnt = 32'hFFFF_FFFE;
    m_cnt[0] = 32'hFFFF_FFFE;
    #1;
    release dut_b4.out_flit_cnt;
    for (int k = 0; k < 5; k++) begin
      drive(4'b1111, 1'b1);
      @(negedge clk);
      chk($sformatf("wrap_cnt%0d", k), 64'(cnt4), 64'(exp_cnt[k]));
    end

    drive(4'b0000, 1'b1);
    @(negedge clk);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
